// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - register-file write port bundle: WB stage, MDU return path, RF write.
interface wb_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [31:0] pend_mask;
  logic        wb_stall_req;

  modport master (
    output wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, rf_we, rf_w_addr, rf_w_data, pend_mask, wb_stall_req
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, rf_we, rf_w_addr, rf_w_data, pend_mask, wb_stall_req
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares one RF write port between WB stage (priority) and a queued MDU return path.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 7
) (
  input logic clk,
  input logic rst,
  wb_port_arbiter_if.slave bus
);
  localparam int         AW  = $clog2(DEPTH);
  localparam logic [4:0] R31 = 5'd31;

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [3:0]       starve_cnt;
  logic             rf_we_q;
  logic [4:0]       rf_addr_q;
  logic [31:0]      rf_data_q;
  logic [31:0]      pend;

  logic wb_slot, empty, full, push, pop;

  assign wb_slot = bus.wb_we && (bus.wb_addr != R31);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = bus.mdu_valid && !full;
  assign pop     = !wb_slot && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= bus.mdu_addr;
      data_q[wr_ptr] <= bus.mdu_data;
    end
  end

  // Liveness is cleared on pop so pend_mask only ever sees occupied slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_slot && addr_q[i] == bus.wb_addr) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        live_q[wr_ptr] <= (bus.mdu_addr != R31) &&
                          !(wb_slot && bus.wb_addr == bus.mdu_addr);
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop || empty)                          starve_cnt <= '0;
      else if (starve_cnt != 4'(STARVE_LIMIT))   starve_cnt <= starve_cnt + 1'b1;

      if (wb_slot) begin
        rf_we_q   <= 1'b1;
        rf_addr_q <= bus.wb_addr;
        rf_data_q <= bus.wb_data;
      end else if (pop) begin
        rf_we_q <= live_q[rd_ptr];
        if (live_q[rd_ptr]) begin
          rf_addr_q <= addr_q[rd_ptr];
          rf_data_q <= data_q[rd_ptr];
        end
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pend[addr_q[i]] = 1'b1;
    end
    pend[31] = 1'b0;
  end

  assign bus.mdu_ready    = !full;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_w_addr    = rf_addr_q;
  assign bus.rf_w_data    = rf_data_q;
  assign bus.pend_mask    = pend;
  assign bus.wb_stall_req = (starve_cnt == 4'(STARVE_LIMIT)) && !empty;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - queue-based reference model checked every cycle, plus directed literal checks.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM   = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  ent_t        e, h;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;
  bit          slot, acc, popn;
  int          n0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pend();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].a] = 1'b1;
    return m;
  endfunction

  // Reference model: the FIFO is a plain queue, entries carry a live flag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0;
    end else begin
      slot = bus.wb_we && bus.wb_addr != 5'd31;
      n0   = q.size();
      acc  = bus.mdu_valid && n0 < DEPTH;
      popn = !slot && n0 > 0;
      if (popn || n0 == 0) m_cnt = 0;
      else if (m_cnt < LIM) m_cnt++;
      if (popn) h = q.pop_front();
      if (acc) begin
        e.a = bus.mdu_addr; e.d = bus.mdu_data; e.live = (bus.mdu_addr != 5'd31);
        q.push_back(e);
      end
      if (slot) foreach (q[i]) if (q[i].a == bus.wb_addr) q[i].live = 0;
      if (slot) begin
        m_we = 1; m_addr = bus.wb_addr; m_data = bus.wb_data;
      end else if (popn) begin
        m_we = h.live;
        if (h.live) begin m_addr = h.a; m_data = h.d; end
      end else begin
        m_we = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_rf_we",   {31'b0, bus.rf_we},        {31'b0, m_we});
    chk("m_rf_addr", {27'b0, bus.rf_w_addr},    {27'b0, m_addr});
    chk("m_rf_data", bus.rf_w_data,             m_data);
    chk("m_pend",    bus.pend_mask,             exp_pend());
    chk("m_ready",   {31'b0, bus.mdu_ready},    {31'b0, q.size() < DEPTH});
    chk("m_stall",   {31'b0, bus.wb_stall_req}, {31'b0, (m_cnt == LIM) && q.size() > 0});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.wb_we = we; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = v; bus.mdu_addr = a; bus.mdu_data = d;
  endtask

  initial begin
    set_wb(0, 0, 0);
    set_mdu(0, 0, 0);
    #8;
    chk("rst_rf_we", {31'b0, bus.rf_we}, 32'd0);
    chk("rst_ready", {31'b0, bus.mdu_ready}, 32'd1);
    chk("rst_pend",  bus.pend_mask, 32'd0);
    chk("rst_stall", {31'b0, bus.wb_stall_req}, 32'd0);
    #4;
    rst = 1'b0;
    set_wb(1, 5, 32'h1234);
    step();
    chk("wb_we",   {31'b0, bus.rf_we}, 32'd1);
    chk("wb_addr", {27'b0, bus.rf_w_addr}, 32'd5);
    chk("wb_data", bus.rf_w_data, 32'h1234);
    set_wb(0, 0, 0);

    set_mdu(1, 7, 32'hAA);
    step();
    set_mdu(0, 0, 0);
    chk("drain_pend1", bus.pend_mask, 32'h80);
    chk("drain_we1",   {31'b0, bus.rf_we}, 32'd0);
    step();
    chk("drain_we2",   {31'b0, bus.rf_we}, 32'd1);
    chk("drain_addr2", {27'b0, bus.rf_w_addr}, 32'd7);
    chk("drain_data2", bus.rf_w_data, 32'hAA);
    chk("drain_pend2", bus.pend_mask, 32'd0);

    set_wb(1, 3, 32'h33);
    set_mdu(1, 9, 32'h99);
    step();
    set_mdu(1, 10, 32'hA0);
    step();
    chk("bp_ready", {31'b0, bus.mdu_ready}, 32'd0);
    set_mdu(1, 11, 32'hB0);
    repeat (5) step();
    chk("starve_pre", {31'b0, bus.wb_stall_req}, 32'd0);
    step();
    chk("starve_req",  {31'b0, bus.wb_stall_req}, 32'd1);
    chk("starve_pend", bus.pend_mask, 32'h600);
    set_wb(0, 0, 0);
    step();
    chk("starve_we",    {31'b0, bus.rf_we}, 32'd1);
    chk("starve_addr",  {27'b0, bus.rf_w_addr}, 32'd9);
    chk("starve_clear", {31'b0, bus.wb_stall_req}, 32'd0);
    chk("starve_ready", {31'b0, bus.mdu_ready}, 32'd1);
    step();
    set_mdu(0, 0, 0);
    chk("pop10_addr", {27'b0, bus.rf_w_addr}, 32'd10);
    step();
    chk("pop11_addr", {27'b0, bus.rf_w_addr}, 32'd11);
    chk("pop11_data", bus.rf_w_data, 32'hB0);
    step();
    chk("empty_we", {31'b0, bus.rf_we}, 32'd0);

    set_wb(1, 2, 32'h22);
    set_mdu(1, 4, 32'h44);
    step();
    set_mdu(0, 0, 0);
    chk("waw_pend_q", bus.pend_mask, 32'h10);
    set_wb(1, 4, 32'h4444);
    step();
    chk("waw_pend_k", bus.pend_mask, 32'd0);
    set_wb(0, 0, 0);
    step();
    chk("waw_pop_we", {31'b0, bus.rf_we}, 32'd0);
    set_wb(1, 6, 32'h66);
    set_mdu(1, 6, 32'h60);
    step();
    set_wb(0, 0, 0);
    set_mdu(0, 0, 0);
    chk("waw_same_pend", bus.pend_mask, 32'd0);
    step();
    chk("waw_same_we", {31'b0, bus.rf_we}, 32'd0);
    set_wb(1, 31, 32'hDEAD);
    set_mdu(1, 31, 32'hBEEF);
    step();
    set_wb(0, 0, 0);
    set_mdu(0, 0, 0);
    chk("r31_we1",   {31'b0, bus.rf_we}, 32'd0);
    chk("r31_pend",  bus.pend_mask, 32'd0);
    step();
    chk("r31_we2",   {31'b0, bus.rf_we}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      set_wb((i % 3) == 0, 5'(i % 4 + 1), 32'h100 + i);
      set_mdu((i % 2) == 0, 5'(i % 5 + 1), 32'h200 + i);
      step();
    end
    set_wb(0, 0, 0);
    set_mdu(0, 0, 0);
    repeat (3) step();

    set_wb(1, 1, 32'h11);
    set_mdu(1, 12, 32'hC0);
    step();
    set_mdu(1, 13, 32'hD0);
    step();
    set_wb(0, 0, 0);
    set_mdu(0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we",    {31'b0, bus.rf_we}, 32'd0);
    chk("mid_rst_addr",  {27'b0, bus.rf_w_addr}, 32'd0);
    chk("mid_rst_data",  bus.rf_w_data, 32'd0);
    chk("mid_rst_pend",  bus.pend_mask, 32'd0);
    chk("mid_rst_ready", {31'b0, bus.mdu_ready}, 32'd1);
    chk("mid_rst_stall", {31'b0, bus.wb_stall_req}, 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_we", {31'b0, bus.rf_we}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
